// File: rtl/proc_test_sequencer.sv
// Drives a reset/run/check test pass on a processor, folding alu_out into a rotate-XOR signature.
// Optional trace buffer of recent alu_out samples enabled by defining PROC_SEQ_TRACE_EN.
module proc_test_sequencer #(
  parameter int XLEN        = 32,
  parameter int RST_CYCLES  = 5,
  parameter int RUN_CYCLES  = 8,
  parameter int TRACE_DEPTH = 4,
  localparam int IDXW       = $clog2(TRACE_DEPTH)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [XLEN-1:0] alu_out,
  input  logic [XLEN-1:0] expected_sig,
  output logic            dut_reset,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [XLEN-1:0] signature,
  output logic [15:0]     cycle_count,
  input  logic [IDXW-1:0] trace_idx,
  output logic [XLEN-1:0] trace_data
);

  typedef enum logic [2:0] {
    IDLE,
    RESET_DUT,
    RUN,
    CHECK,
    DONE
  } state_t;

  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] RUN_LAST = 16'(RUN_CYCLES - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] rst_cnt;
  logic [15:0] run_cnt;
  logic        begin_run;

  // start is only honoured when no run is in flight
  assign begin_run = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (start) state_nxt = RESET_DUT;
      RESET_DUT: if (rst_cnt == RST_LAST) state_nxt = RUN;
      RUN:       if (run_cnt == RUN_LAST) state_nxt = CHECK;
      CHECK:     state_nxt = DONE;
      DONE:      if (start) state_nxt = RESET_DUT;
      default:   state_nxt = IDLE;
    endcase
  end

  // Status outputs are registered alongside the state so they change on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      dut_reset <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      dut_reset <= (state_nxt != RUN);
      busy      <= (state_nxt == RESET_DUT) || (state_nxt == RUN) || (state_nxt == CHECK);
      done      <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      signature   <= '0;
      cycle_count <= '0;
      pass        <= 1'b0;
      rst_cnt     <= '0;
      run_cnt     <= '0;
    end else if (begin_run) begin
      signature   <= '0;
      cycle_count <= '0;
      pass        <= 1'b0;
      rst_cnt     <= '0;
      run_cnt     <= '0;
    end else begin
      case (state)
        RESET_DUT: rst_cnt <= rst_cnt + 16'd1;
        RUN: begin
          signature   <= {signature[XLEN-2:0], signature[XLEN-1]} ^ alu_out;
          cycle_count <= (cycle_count == 16'hFFFF) ? cycle_count : cycle_count + 16'd1;
          run_cnt     <= run_cnt + 16'd1;
        end
        CHECK:   pass <= (signature == expected_sig);
        default: ;
      endcase
    end
  end

`ifdef PROC_SEQ_TRACE_EN
  logic [XLEN-1:0] trace_mem [TRACE_DEPTH];
  logic [IDXW-1:0] wr_ptr;
  logic [IDXW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (reset || begin_run) begin
      for (int i = 0; i < TRACE_DEPTH; i++) trace_mem[i] <= '0;
      wr_ptr <= '0;
    end else if (state == RUN) begin
      trace_mem[wr_ptr] <= alu_out;
      wr_ptr            <= wr_ptr + IDXW'(1);
    end
  end

  // Once the buffer has wrapped, the write pointer addresses the oldest sample.
  assign rd_ptr     = wr_ptr + trace_idx;
  assign trace_data = trace_mem[rd_ptr];
`else
  logic unused_trace_idx;
  assign unused_trace_idx = ^trace_idx;
  assign trace_data       = '0;
`endif

endmodule

// File: tb/tb_proc_test_sequencer.sv
// Directed bench for proc_test_sequencer: reset, signature runs, mid-run reset, ignored start, trace.
module tb_proc_test_sequencer;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, start6;
  logic [7:0] alu, alu6, exp_sig, exp6;
  logic [1:0] idx, idx6;
  logic       dut_reset, busy, done, pass;
  logic       dut_reset6, busy6, done6, pass6;
  logic [7:0] sig, sig6, tdata, tdata6;
  logic [15:0] cc, cc6;

  int nvec = 0;
  int nerr = 0;

  proc_test_sequencer #(.XLEN(8), .RST_CYCLES(5), .RUN_CYCLES(4), .TRACE_DEPTH(4)) u_dut (
    .clk(clk), .reset(reset), .start(start), .alu_out(alu), .expected_sig(exp_sig),
    .dut_reset(dut_reset), .busy(busy), .done(done), .pass(pass), .signature(sig),
    .cycle_count(cc), .trace_idx(idx), .trace_data(tdata)
  );

  proc_test_sequencer #(.XLEN(8), .RST_CYCLES(5), .RUN_CYCLES(6), .TRACE_DEPTH(4)) u_dut6 (
    .clk(clk), .reset(reset), .start(start6), .alu_out(alu6), .expected_sig(exp6),
    .dut_reset(dut_reset6), .busy(busy6), .done(done6), .pass(pass6), .signature(sig6),
    .cycle_count(cc6), .trace_idx(idx6), .trace_data(tdata6)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  logic [7:0] sig_tab [4];
  logic [7:0] texp;

  initial begin
    sig_tab = '{8'h00, 8'h01, 8'h03, 8'h07};
    reset = 1'b1; start = 1'b0; start6 = 1'b0;
    alu = '0; alu6 = '0; exp_sig = '0; exp6 = '0; idx = '0; idx6 = '0;
    step();
    step();
    check("rst_dut_reset", 32'(dut_reset), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_sig", 32'(sig), 32'd0);
    check("rst_cc", 32'(cc), 32'd0);
    check("rst_trace", 32'(tdata), 32'd0);
    reset = 1'b0;

    // constant 01, golden 0F: timing of dut_reset and signature progression
    alu = 8'h01; exp_sig = 8'h0F;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      check("hold_dut_reset", 32'(dut_reset), 32'd1);
      check("hold_busy", 32'(busy), 32'd1);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      check("run_dut_reset", 32'(dut_reset), 32'd0);
      check("run_sig", 32'(sig), 32'(sig_tab[i]));
      step();
    end
    check("chk_sig", 32'(sig), 32'h0F);
    check("chk_cc", 32'(cc), 32'd4);
    check("chk_dut_reset", 32'(dut_reset), 32'd1);
    check("chk_done", 32'(done), 32'd0);
    step();
    check("a_done", 32'(done), 32'd1);
    check("a_pass", 32'(pass), 32'd1);
    check("a_busy", 32'(busy), 32'd0);
    step();
    step();
    check("a_hold_sig", 32'(sig), 32'h0F);
    check("a_hold_done", 32'(done), 32'd1);

    // golden mismatch, restarted from DONE
    exp_sig = 8'h0E;
    pulse_start();
    check("b_clr_sig", 32'(sig), 32'd0);
    check("b_clr_cc", 32'(cc), 32'd0);
    repeat (10) step();
    check("b_done", 32'(done), 32'd1);
    check("b_pass", 32'(pass), 32'd0);
    check("b_sig", 32'(sig), 32'h0F);

    // MSB set exercises the rotate wrap: 80,81,83,87
    alu = 8'h80; exp_sig = 8'h87;
    pulse_start();
    repeat (10) step();
    check("c_sig", 32'(sig), 32'h87);
    check("c_pass", 32'(pass), 32'd1);

    // reset on the second RUN cycle
    alu = 8'h01; exp_sig = 8'h0F;
    pulse_start();
    repeat (6) step();
    check("d_mid_sig", 32'(sig), 32'h01);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("d_busy", 32'(busy), 32'd0);
    check("d_dut_reset", 32'(dut_reset), 32'd1);
    check("d_sig", 32'(sig), 32'd0);
    check("d_done", 32'(done), 32'd0);
    check("d_cc", 32'(cc), 32'd0);
    step();
    check("d_idle", 32'(busy), 32'd0);
    pulse_start();
    repeat (10) step();
    check("d2_done", 32'(done), 32'd1);
    check("d2_pass", 32'(pass), 32'd1);
    check("d2_sig", 32'(sig), 32'h0F);
    check("d2_cc", 32'(cc), 32'd4);

    // start during RUN ignored; start in DONE restarts
    pulse_start();
    repeat (6) step();
    pulse_start();
    check("e_busy", 32'(busy), 32'd1);
    check("e_cc", 32'(cc), 32'd2);
    check("e_dut_reset", 32'(dut_reset), 32'd0);
    repeat (3) step();
    check("e_done", 32'(done), 32'd1);
    check("e_cc_final", 32'(cc), 32'd4);
    check("e_sig", 32'(sig), 32'h0F);
    pulse_start();
    check("e_restart_sig", 32'(sig), 32'd0);
    check("e_restart_busy", 32'(busy), 32'd1);
    check("e_restart_done", 32'(done), 32'd0);

    // reset and start together
    reset = 1'b1; start = 1'b1;
    step();
    reset = 1'b0; start = 1'b0;
    check("f_busy", 32'(busy), 32'd0);
    check("f_dut_reset", 32'(dut_reset), 32'd1);

    // trace on the six-cycle instance, alu_out = 1..6
    start6 = 1'b1;
    step();
    start6 = 1'b0;
    repeat (5) step();
    for (int i = 1; i <= 6; i++) begin
      alu6 = 8'(i);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      idx6 = 2'(i);
      #1;
`ifdef PROC_SEQ_TRACE_EN
      texp = 8'(3 + i);
`else
      texp = 8'h00;
`endif
      check("trace", 32'(tdata6), 32'(texp));
    end
    check("t_sig", 32'(sig6), 32'h04);
    check("t_cc", 32'(cc6), 32'd6);
    step();
    check("t_done", 32'(done6), 32'd1);
    check("t_pass", 32'(pass6), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end
endmodule
